// File: rtl/data_mem_responder.sv
// Word-addressed data memory acting as responder on the CPU load/store valid/ready interface.
// Define DMEM_MISALIGN_ERR_EN to fault accesses whose byte address is not word aligned.
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_be,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err
);

    localparam int unsigned NB     = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
    localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(DEPTH_WORDS);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           be_q, be_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // With no wait states the commit happens on the accept edge, so the live request is used there.
    logic                    txn_live;
    logic                    txn_we;
    logic [ADDR_WIDTH-1:0]   txn_addr;
    logic [DATA_WIDTH-1:0]   txn_wdata;
    logic [NB-1:0]           txn_be;
    logic [WIDX_W-1:0]       word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    range_err;
    logic                    misalign_err;
    logic                    txn_err;
    logic                    enter_resp;
    logic                    commit_we;

    assign txn_live  = (state_q == S_IDLE);
    assign txn_we    = txn_live ? i_req_we    : we_q;
    assign txn_addr  = txn_live ? i_req_addr  : addr_q;
    assign txn_wdata = txn_live ? i_req_wdata : wdata_q;
    assign txn_be    = txn_live ? i_req_be    : be_q;

    assign word_idx  = txn_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign range_err = (word_idx >= DEPTH_IDX);

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign_err = |txn_addr[1:0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^txn_addr[1:0];
    assign misalign_err    = 1'b0;
`endif

    assign txn_err   = range_err | misalign_err;
    assign commit_we = enter_resp & txn_we & ~txn_err;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        enter_resp  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid && ready_q) begin
                    we_d    = i_req_we;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    be_d    = i_req_be;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = S_RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            err_d       = txn_err;
            rdata_d     = (!txn_we && !txn_err) ? mem[mem_idx] : '0;
        end

        ready_d = (state_d == S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // NOTE: the storage array is deliberately not reset; contents survive reset and it maps to RAM.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && commit_we) begin
            for (int b = 0; b < NB; b++) begin
                if (txn_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= txn_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 uses one wait state, instance 1 uses three.
// Expected responses are queued by the driver and checked by an independent monitor.
module tb_data_mem_responder;

    localparam int WS0 = 1;
    localparam int WS1 = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n   [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_valid [2] = '{1'b0, 1'b0};
    logic after_hs   [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.WAIT_STATES(WS0)) u_dut0 (
        .i_clk(clk), .i_reset_n(reset_n[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_we(req_we[0]), .i_req_addr(req_addr[0]),
        .i_req_wdata(req_wdata[0]), .i_req_be(req_be[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
    );

    data_mem_responder #(.WAIT_STATES(WS1)) u_dut1 (
        .i_clk(clk), .i_reset_n(reset_n[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_we(req_we[1]), .i_req_addr(req_addr[1]),
        .i_req_wdata(req_wdata[1]), .i_req_be(req_be[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor: one step per DUT on every falling edge.
    task automatic mon(input int d);
        exp_t e;
        int   ws;
        ws = (d == 0) ? WS0 : WS1;
        if (after_hs[d]) begin
            check($sformatf("d%0d_post_hs_valid", d), rsp_valid[d], 0);
            check($sformatf("d%0d_post_hs_ready", d), req_ready[d], 1);
            check($sformatf("d%0d_post_hs_rdata", d), rsp_rdata[d], 0);
            check($sformatf("d%0d_post_hs_err", d),   rsp_err[d],   0);
            after_hs[d] = 1'b0;
        end
        if (rsp_valid[d] === 1'b1) begin
            if (qsize(d) == 0) begin
                check($sformatf("d%0d_spurious_valid", d), rsp_valid[d], 0);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                if (!prev_valid[d])
                    check($sformatf("d%0d_latency", d), 32'(cyc - e.acc), 32'(ws + 1));
                check($sformatf("d%0d_rdata", d),        rsp_rdata[d], e.rdata);
                check($sformatf("d%0d_err", d),          rsp_err[d],   e.err);
                check($sformatf("d%0d_ready_in_resp", d), req_ready[d], 0);
                if (rsp_ready[d]) begin
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    after_hs[d] = 1'b1;
                end
            end
        end
        prev_valid[d] = (rsp_valid[d] === 1'b1);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic push, input logic [31:0] exp_rdata, input logic exp_err);
        int   t;
        exp_t e;
        @(negedge clk);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        t = 0;
        while (req_ready[d] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("d%0d_req_accept", d), req_ready[d], 1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cyc;
        if (push) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (qsize(d) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("d%0d_drained", d), qsize(d), 0);
    endtask

    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
        issue(d, we, addr, wdata, be, 1'b1, exp_rdata, exp_err);
        drain(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_n[d]   = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rst_req_ready", d), req_ready[d], 0);
            check($sformatf("d%0d_rst_rsp_valid", d), rsp_valid[d], 0);
            check($sformatf("d%0d_rst_rdata", d),     rsp_rdata[d], 0);
            check($sformatf("d%0d_rst_err", d),       rsp_err[d],   0);
        end
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;

        // Instance 0, one wait state.
        xact(0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        xact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_AAEF, 1'b0);

        // Response backpressure: hold the response for five cycles.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'hDEAD_AAEF, 1'b0);
        for (int t = 0; t < 20 && rsp_valid[0] !== 1'b1; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        rsp_ready[0] = 1'b1;
        drain(0);

        // Out-of-range stores must not wrap onto low words.
        xact(0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        xact(0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
        xact(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
        xact(0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0);

        // Last in-range word and an all-zero byte enable.
        xact(0, 1'b1, 32'h0000_0FFC, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0);
        xact(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'h0, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0);

`ifdef DMEM_MISALIGN_ERR_EN
        xact(0, 1'b0, 32'h0000_0012, 32'h0, 4'h0, 32'h0, 1'b1);
`else
        xact(0, 1'b0, 32'h0000_0012, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0);
`endif

        // Instance 1, three wait states: reset during WAIT abandons the store.
        xact(1, 1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0);
        xact(1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h0BAD_C0DE, 1'b0);
        issue(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0);
        reset_n[1] = 1'b0;
        @(negedge clk);
        check("d1_midrst_req_ready", req_ready[1], 0);
        check("d1_midrst_rsp_valid", rsp_valid[1], 0);
        check("d1_midrst_rdata",     rsp_rdata[1], 0);
        check("d1_midrst_err",       rsp_err[1],   0);
        reset_n[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("d1_post_rst_rsp_valid", rsp_valid[1], 0);
        xact(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
